// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
//   Single-slave SPI bus master, SPI mode 2 (CPOL=1, CPHA=0), LSB first.
//   SCK idles high. MOSI changes on SCK falling edges and MISO is captured on
//   SCK rising edges. Every output comes straight from a register, so SCK,
//   SS and MOSI are glitch-free.
//
//   Parameters
//     DATA_WIDTH : bits per transfer (must match the slave)
//     CLK_DIV    : SCK half-period in clk cycles (>=1)
//     SS_LEAD    : clk cycles from SS falling to the first SCK fall (>=1)
//     SS_LAG     : clk cycles from the last SCK rise to SS rising (>=1)
//     SS_GAP     : clk cycles from SS rising to ready (>=1)
//
//   Ports
//     clk      in   system clock, rising-edge active
//     reset    in   asynchronous reset, active low
//     start    in   transfer request, taken only while the master is idle
//     tx_data  in   word to send, sampled when start is accepted
//     ready    out  master idle and able to accept start
//     rx_data  out  last received word, held until the next rx_valid
//     rx_valid out  one-cycle pulse, rx_data updated in the same cycle
//     SCK      out  serial clock (idles high)
//     SS       out  slave select, active low
//     MOSI     out  serial data out
//     MISO     in   serial data in (ignored while SS is high)
// -----------------------------------------------------------------------------
module spi_master #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 2,
    parameter int SS_LEAD    = 1,
    parameter int SS_LAG     = 1,
    parameter int SS_GAP     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  SCK,
    output logic                  SS,
    output logic                  MOSI,
    input  logic                  MISO
);

    // One down-counter serves the lead, half-period, lag and gap intervals,
    // so it is sized for the longest of them.
    localparam int M1      = (SS_LEAD > CLK_DIV) ? SS_LEAD : CLK_DIV;
    localparam int M2      = (SS_LAG > SS_GAP) ? SS_LAG : SS_GAP;
    localparam int CNT_MAX = ((M1 > M2) ? M1 : M2) - 1;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
    localparam int BIT_W   = (DATA_WIDTH < 2) ? 1 : $clog2(DATA_WIDTH);

    localparam logic [CNT_W-1:0] LEAD_LOAD = CNT_W'(SS_LEAD - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] LAG_LOAD  = CNT_W'(SS_LAG - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(SS_GAP - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        XFER,
        LAG,
        GAP
    } state_t;

    state_t                  r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [BIT_W-1:0]        r_bit_cnt;
    logic [DATA_WIDTH-1:0]   r_tx;
    logic [DATA_WIDTH-1:0]   r_rx;
    logic [DATA_WIDTH-1:0]   r_rx_data;
    logic                    r_rx_valid;
    logic                    r_ready;
    logic                    r_sck;
    logic                    r_ss;
    logic                    r_mosi;

    logic                    w_gap_done;
    logic                    w_accept;

    // A request is also taken on the last GAP cycle, the same edge on which
    // ready would otherwise rise. With start held high this keeps SS high
    // for exactly SS_GAP cycles between back-to-back transfers.
    assign w_gap_done = (r_state == GAP) && (r_cnt == '0);
    assign w_accept   = start && ((r_state == IDLE) || w_gap_done);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_bit_cnt  <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_ready    <= 1'b1;
            r_sck      <= 1'b1;
            r_ss       <= 1'b1;
            r_mosi     <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_accept) begin
                r_tx      <= tx_data;
                r_bit_cnt <= '0;
                r_cnt     <= LEAD_LOAD;
                r_ss      <= 1'b0;
                r_ready   <= 1'b0;
                r_state   <= LEAD;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        r_ready <= 1'b1;
                    end
                    LEAD: begin
                        if (r_cnt == '0) begin
                            // First falling edge presents bit 0.
                            r_sck   <= 1'b0;
                            r_mosi  <= r_tx[0];
                            r_tx    <= r_tx >> 1;
                            r_cnt   <= DIV_LOAD;
                            r_state <= XFER;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    XFER: begin
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - 1'b1;
                        end else if (!r_sck) begin
                            // Rising edge: capture MISO into the MSB, shift right.
                            r_sck <= 1'b1;
                            r_rx  <= (r_rx >> 1) | (DATA_WIDTH'(MISO) << (DATA_WIDTH - 1));
                            if (r_bit_cnt == BIT_LAST) begin
                                r_cnt   <= LAG_LOAD;
                                r_state <= LAG;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                                r_cnt     <= DIV_LOAD;
                            end
                        end else begin
                            // Falling edge: present the next bit.
                            r_sck  <= 1'b0;
                            r_mosi <= r_tx[0];
                            r_tx   <= r_tx >> 1;
                            r_cnt  <= DIV_LOAD;
                        end
                    end
                    LAG: begin
                        if (r_cnt == '0) begin
                            r_ss       <= 1'b1;
                            r_mosi     <= 1'b0;
                            r_rx_data  <= r_rx;
                            r_rx_valid <= 1'b1;
                            r_cnt      <= GAP_LOAD;
                            r_state    <= GAP;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    GAP: begin
                        if (r_cnt == '0) begin
                            r_ready <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign ready    = r_ready;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign SCK      = r_sck;
    assign SS       = r_ss;
    assign MOSI     = r_mosi;

endmodule

// File: tb/tb_spi_master.sv
// -----------------------------------------------------------------------------
// tb_spi_master
//   Two masters share start/tx_data/reset: instance 0 uses default timing,
//   instance 1 uses CLK_DIV=1, SS_LEAD=3, SS_LAG=2, SS_GAP=2. Each has a
//   behavioural slave and a timeline model: after an acceptance edge T0 the
//   expected outputs are a pure function of n = cycles since T0.
// -----------------------------------------------------------------------------
module tb_spi_master;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [7:0]       tx_data = 8'h00;
    logic [1:0]       rdy, rv, sck, ss, mosi;
    logic [1:0]       miso = 2'b00;
    logic [1:0][7:0]  rxd;

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            spi_master #(
                .DATA_WIDTH(8),
                .CLK_DIV   ((gi == 0) ? 2 : 1),
                .SS_LEAD   ((gi == 0) ? 1 : 3),
                .SS_LAG    ((gi == 0) ? 1 : 2),
                .SS_GAP    ((gi == 0) ? 1 : 2)
            ) u_dut (
                .clk     (clk),
                .reset   (reset),
                .start   (start),
                .tx_data (tx_data),
                .ready   (rdy[gi]),
                .rx_data (rxd[gi]),
                .rx_valid(rv[gi]),
                .SCK     (sck[gi]),
                .SS      (ss[gi]),
                .MOSI    (mosi[gi]),
                .MISO    (miso[gi])
            );
        end
    endgenerate

    function automatic int p_lead(int i); return (i == 0) ? 1 : 3; endfunction
    function automatic int p_div (int i); return (i == 0) ? 2 : 1; endfunction
    function automatic int p_lag (int i); return (i == 0) ? 1 : 2; endfunction
    function automatic int p_gap (int i); return (i == 0) ? 1 : 2; endfunction

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    // reference model state
    bit         busy_m[2];
    int         n_m[2];
    logic [7:0] txw_m[2];
    logic [7:0] exp_rx[2];

    // slave / observation state
    logic [7:0] slave_next[2], slave_cur[2], srx[2], hist_last[2], hist_prev[2];
    int fall_c[2], rise_c[2], t_ss[2], first_fall[2], t_last_rise[2];
    int t_rv[2], t_rv_prev[2], t_rdy[2], t_ss_rise[2], ss_high[2];
    int n_xfer[2], n_rv[2], n_edges[2];
    bit prev_ss[2], prev_sck[2], prev_rdy[2];

    task automatic chk(input string name, input int inst, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s inst=%0d cyc=%0d: got %0h want %0h", name, inst, cyc, got, want);
    endtask

    // Expected {SCK,SS,MOSI,ready,rx_valid,rx_data} from the transfer timeline.
    function automatic logic [12:0] exp_out(int i);
        int lead, div, lag, gap, tl, n, k;
        logic s_sck, s_ss, s_mosi, s_rdy, s_rv;
        lead = p_lead(i); div = p_div(i); lag = p_lag(i); gap = p_gap(i);
        tl = lead + 15 * div;
        n  = n_m[i];
        s_sck = 1'b1; s_ss = 1'b1; s_mosi = 1'b0; s_rdy = 1'b1; s_rv = 1'b0;
        if (busy_m[i] && n < tl + lag + gap) begin
            s_rdy = 1'b0;
            s_ss  = (n < tl + lag) ? 1'b0 : 1'b1;
            if (n >= lead && n <= tl) s_sck = (((n - lead) / div) % 2) == 1;
            if (n >= lead && n < tl + lag) begin
                k = (n - lead) / (2 * div);
                if (k > 7) k = 7;
                s_mosi = txw_m[i][k];
            end
            s_rv = (n == tl + lag);
        end
        return {s_sck, s_ss, s_mosi, s_rdy, s_rv, exp_rx[i]};
    endfunction

    task automatic model_step(int i);
        int tl, n_end;
        tl    = p_lead(i) + 15 * p_div(i);
        n_end = tl + p_lag(i) + p_gap(i);
        if (!reset) begin
            busy_m[i] = 1'b0; n_m[i] = 0; exp_rx[i] = 8'h00;
        end else if (!busy_m[i] || n_m[i] == n_end - 1) begin
            if (start) begin
                busy_m[i] = 1'b1; n_m[i] = 0; txw_m[i] = tx_data;
            end else begin
                busy_m[i] = 1'b0;
            end
        end else begin
            n_m[i]++;
            if (n_m[i] == tl + p_lag(i)) exp_rx[i] = slave_cur[i];
        end
    endtask

    task automatic slave_step(int i);
        if (!reset) begin
            fall_c[i] = 0; rise_c[i] = 0; srx[i] = 8'h00;
            prev_ss[i] = 1'b1; prev_sck[i] = 1'b1; prev_rdy[i] = 1'b1;
            return;
        end
        if (prev_ss[i] && !ss[i]) begin
            slave_cur[i] = slave_next[i];
            fall_c[i] = 0; rise_c[i] = 0; first_fall[i] = -1;
            ss_high[i] = cyc - t_ss_rise[i];
            t_ss[i] = cyc; n_xfer[i]++;
        end
        if (prev_sck[i] != sck[i]) n_edges[i]++;
        if (!ss[i] && prev_sck[i] && !sck[i]) begin
            miso[i] = slave_cur[i][fall_c[i] & 7];
            fall_c[i]++;
            if (first_fall[i] < 0) first_fall[i] = cyc;
        end
        if (!ss[i] && !prev_sck[i] && sck[i]) begin
            srx[i] = {mosi[i], srx[i][7:1]};
            rise_c[i]++;
            t_last_rise[i] = cyc;
        end
        if (!prev_ss[i] && ss[i]) begin
            chk("slave_word", i, 32'(srx[i]), 32'(txw_m[i]));
            chk("edge_count", i, 32'({fall_c[i][7:0], rise_c[i][7:0]}), 32'h0808);
            hist_prev[i] = hist_last[i]; hist_last[i] = srx[i];
            t_ss_rise[i] = cyc;
        end
        if (ss[i]) miso[i] = 1'($urandom);
        if (rv[i]) begin t_rv_prev[i] = t_rv[i]; t_rv[i] = cyc; n_rv[i]++; end
        if (!prev_rdy[i] && rdy[i]) t_rdy[i] = cyc;
        prev_ss[i] = ss[i]; prev_sck[i] = sck[i]; prev_rdy[i] = rdy[i];
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) model_step(i);
        for (int i = 0; i < 2; i++)
            chk("cycle_outputs", i, 32'({sck[i], ss[i], mosi[i], rdy[i], rv[i], rxd[i]}), 32'(exp_out(i)));
        for (int i = 0; i < 2; i++) slave_step(i);
    endtask

    task automatic wait_idle(int bound);
        int k = 0;
        while (!(rdy == 2'b11 && ss == 2'b11) && k < bound) begin
            tick();
            k++;
        end
        chk("idle_within_bound", 0, 32'({rdy, ss}), 32'hF);
    endtask

    // One transfer on both instances with literal timing/data expectations.
    task automatic run_one(input logic [7:0] tx, input logic [7:0] sl);
        int base;
        slave_next[0] = sl; slave_next[1] = sl;
        start = 1'b1; tx_data = tx;
        tick();
        base = cyc;
        start = 1'b0; tx_data = 8'($urandom);
        wait_idle(100);
        for (int i = 0; i < 2; i++) begin
            chk("ss_fall_T0", i, 32'(t_ss[i] - base), 0);
            chk("first_fall", i, 32'(first_fall[i] - base), (i == 0) ? 1 : 3);
            chk("last_rise", i, 32'(t_last_rise[i] - base), (i == 0) ? 31 : 18);
            chk("rx_valid_time", i, 32'(t_rv[i] - base), (i == 0) ? 32 : 20);
            chk("ready_time", i, 32'(t_rdy[i] - base), (i == 0) ? 33 : 22);
            chk("mosi_bits", i, 32'(hist_last[i]), 32'(tx));
            chk("rx_data", i, 32'(rxd[i]), 32'(sl));
        end
    endtask

    initial begin
        int base, x0[2], r0[2], e0[2];
        for (int i = 0; i < 2; i++) begin
            busy_m[i] = 0; n_m[i] = 0; txw_m[i] = 0; exp_rx[i] = 0;
            slave_next[i] = 0; slave_cur[i] = 0; srx[i] = 0; hist_last[i] = 0; hist_prev[i] = 0;
            fall_c[i] = 0; rise_c[i] = 0; t_ss[i] = 0; first_fall[i] = -1; t_last_rise[i] = 0;
            t_rv[i] = 0; t_rv_prev[i] = 0; t_rdy[i] = 0; t_ss_rise[i] = 0; ss_high[i] = 0;
            n_xfer[i] = 0; n_rv[i] = 0; n_edges[i] = 0;
            prev_ss[i] = 1; prev_sck[i] = 1; prev_rdy[i] = 1;
        end
        #2 reset = 1'b0;

        // Reset values
        repeat (3) tick();
        for (int i = 0; i < 2; i++)
            chk("reset_values", i, 32'({sck[i], ss[i], mosi[i], rdy[i], rv[i], rxd[i]}), 32'h1A00);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) e0[i] = n_edges[i];
        repeat (50) tick();
        for (int i = 0; i < 2; i++) chk("no_sck_after_reset", i, 32'(n_edges[i] - e0[i]), 0);

        // Single transfer, defaults and swept parameters
        run_one(8'hA5, 8'hCA);
        run_one(8'h01, 8'h6B);

        // Back-to-back with start held
        for (int i = 0; i < 2; i++) x0[i] = n_xfer[i];
        slave_next[0] = 8'h99; slave_next[1] = 8'h99;
        start = 1'b1; tx_data = 8'h3C;
        tick();
        base = cyc;
        tx_data = 8'hF0;
        repeat (33) tick();
        start = 1'b0;
        wait_idle(100);
        for (int i = 0; i < 2; i++) begin
            chk("b2b_count", i, 32'(n_xfer[i] - x0[i]), 2);
            chk("b2b_first", i, 32'(hist_prev[i]), 32'h3C);
            chk("b2b_second", i, 32'(hist_last[i]), 32'hF0);
            chk("b2b_accept2", i, 32'(t_ss[i] - base), (i == 0) ? 33 : 22);
            chk("b2b_ss_high", i, 32'(ss_high[i]), (i == 0) ? 1 : 2);
            chk("b2b_rv_spacing", i, 32'(t_rv[i] - t_rv_prev[i]), (i == 0) ? 33 : 22);
        end

        // Start while busy is ignored
        for (int i = 0; i < 2; i++) x0[i] = n_xfer[i];
        slave_next[0] = 8'h17; slave_next[1] = 8'h17;
        start = 1'b1; tx_data = 8'h5A;
        tick();
        start = 1'b0; tx_data = 8'h00;
        repeat (9) tick();
        start = 1'b1; tx_data = 8'hFF;
        tick();
        start = 1'b0;
        wait_idle(100);
        repeat (5) tick();
        for (int i = 0; i < 2; i++) begin
            chk("busy_one_xfer", i, 32'(n_xfer[i] - x0[i]), 1);
            chk("busy_word", i, 32'(hist_last[i]), 32'h5A);
        end

        // Mid-transfer reset after the 3rd rising edge of instance 0
        for (int i = 0; i < 2; i++) r0[i] = n_rv[i];
        slave_next[0] = 8'h3E; slave_next[1] = 8'h3E;
        start = 1'b1; tx_data = 8'hC3;
        tick();
        start = 1'b0;
        begin
            int k = 0;
            while (rise_c[0] < 3 && k < 100) begin tick(); k++; end
        end
        chk("third_rise_seen", 0, 32'(rise_c[0]), 3);
        reset = 1'b0;
        #1;
        chk("reset_sck_ss_now", 0, 32'({sck, ss}), 32'hF);
        repeat (3) tick();
        reset = 1'b1;
        repeat (5) tick();
        for (int i = 0; i < 2; i++) chk("no_rv_on_abort", i, 32'(n_rv[i] - r0[i]), 0);
        run_one(8'h81, 8'hD2);

        // Randomized traffic with occasional resets
        repeat (1500) begin
            start   = ($urandom_range(0, 3) == 0);
            tx_data = 8'($urandom);
            slave_next[0] = 8'($urandom);
            slave_next[1] = 8'($urandom);
            reset = ($urandom_range(0, 299) != 0);
            tick();
        end
        reset = 1'b1; start = 1'b0;
        wait_idle(100);
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/spi_master.md
# spi_master

Single-slave SPI bus master for the SPI BUS project, running in the system clock domain. It is the upstream stage that drives `spi_slave`: it generates SCK, SS and MOSI, and it captures MISO. The bus runs in SPI mode 2 (CPOL=1, CPHA=0), LSB first. The parallel side uses a ready/start handshake on the transmit side and a one-cycle valid pulse on the receive side.

## Interface
- `DATA_WIDTH`, default 8: bits per transfer; must match the slave.
- `CLK_DIV`, default 2: SCK half-period in `clk` cycles; legal range ≥1.
- `SS_LEAD`, default 1: `clk` cycles from SS falling to the first SCK falling edge; legal range ≥1.
- `SS_LAG`, default 1: `clk` cycles from the last SCK rising edge to SS rising; legal range ≥1.
- `SS_GAP`, default 1: `clk` cycles from SS rising to `ready` high; legal range ≥1.

Ports (name, direction, width, meaning):
- `clk` input 1: system clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-low reset; shared with the slave.
- `start` input 1: request a transfer; accepted only when `ready`=1.
- `tx_data` input DATA_WIDTH: word to send; sampled at acceptance.
- `ready` output 1: master idle and able to accept `start`.
- `rx_data` output DATA_WIDTH: last received word; held until the next `rx_valid`.
- `rx_valid` output 1: one-cycle pulse; `rx_data` is updated in the same cycle.
- `SCK` output 1: serial clock; idles high.
- `SS` output 1: slave select, active low.
- `MOSI` output 1: serial data out.
- `MISO` input 1: serial data in; high-Z from the slave when SS=1, and ignored then.

## Operation
- FSM states: IDLE, LEAD, XFER, LAG, GAP. One down-counter is reused for the lead, half-period, lag and gap timing. A bit counter runs 0..DATA_WIDTH-1.
- **IDLE**: `ready`=1, SS=1, SCK=1, MOSI=0.
  - On `start`=1, the master latches `tx_data` into the TX shift register, clears the bit counter, drives SS=0 and `ready`=0, and moves to LEAD.
- **LEAD**: waits SS_LEAD cycles, then drives SCK=0 with MOSI=tx[0] and enters XFER.
- **XFER**: SCK toggles every CLK_DIV cycles.
  - On each SCK fall, MOSI is driven with the next bit; the TX register shifts right.
  - On each SCK rise, the RX shift register captures MISO in the same clock cycle: rx <= {MISO, rx[W-1:1]}.
  - After the DATA_WIDTH-th rising edge, SCK stays at 1 and the FSM enters LAG.
- **LAG**: waits SS_LAG cycles, then drives SS=1 and MOSI=0, loads `rx_data` from the RX register, pulses `rx_valid`, and enters GAP.
- **GAP**: waits SS_GAP cycles, then sets `ready`=1 and returns to IDLE.
- `start` is ignored whenever `ready`=0. `tx_data` changes after acceptance have no effect.
- Exactly DATA_WIDTH falling and DATA_WIDTH rising SCK edges occur per SS-low window. This keeps the slave's bit counter aligned.
- **Reset** (asynchronous, at any time, including mid-transfer): the transfer aborts immediately and no `rx_valid` is produced.
  - Output values in reset: SCK=1, SS=1, MOSI=0, `ready`=1, `rx_valid`=0, `rx_data`=0.
  - The FSM is in IDLE and all counters are 0.
  - After reset release, no SCK edge occurs before a new `start`.

## Timing
- All outputs are registered; SCK, SS and MOSI are glitch-free.
- Define T0 as the `clk` edge where `start`=1 and `ready`=1.
  - SS falls at T0.
  - Falling edge k (k = 0..W-1) occurs at T0+SS_LEAD+2k·CLK_DIV.
  - Rising edge k occurs at T0+SS_LEAD+(2k+1)·CLK_DIV.
- The last rising edge is at T0+SS_LEAD+(2W-1)·CLK_DIV = TL.
- SS rises and `rx_valid` pulses at TL+SS_LAG. `ready` rises at TL+SS_LAG+SS_GAP.
- With defaults: first SCK fall at T0+1, last rise at T0+31, SS high and `rx_valid` at T0+32, `ready` at T0+33. A transfer takes 33 cycles, start to start.
- If `start` is held high, the next acceptance occurs in the cycle `ready` rises. SS is then high for exactly SS_GAP cycles.
- MOSI is stable for CLK_DIV cycles before each rising edge. MISO is sampled CLK_DIV cycles after the slave's falling-edge update.

## Test plan
- **Reset values**: assert `reset`=0 → SCK=1, SS=1, MOSI=0, `ready`=1, `rx_valid`=0, `rx_data`=0. There is no SCK activity for 50 cycles after release with `start`=0.
- **Single transfer with defaults**: `tx_data`=8'hA5, slave preloaded with 8'hCA.
  - MOSI at the rising edges is 1,0,1,0,0,1,0,1.
  - Slave `rx_reg`=8'hA5.
  - `rx_data`=8'hCA, with `rx_valid` at T0+32 and `ready` at T0+33.
- **Back-to-back**: `start` held high with `tx_data`=8'h3C then 8'hF0.
  - Second acceptance at T0+33; SS high for exactly 1 cycle.
  - Slave receives 8'h3C then 8'hF0.
  - Two `rx_valid` pulses, 33 cycles apart.
- **Start while busy**: pulse `start` with `tx_data`=8'hFF at T0+10 during an 8'h5A transfer → ignored. The slave receives 8'h5A, and only one transfer occurs.
- **Mid-transfer reset**: assert `reset` after the 3rd rising edge.
  - SCK and SS go to 1 immediately, with no `rx_valid`.
  - After release, a transfer of 8'h81 completes correctly at both ends.
- **Parameter sweep**: CLK_DIV=1, SS_LEAD=3, SS_LAG=2, SS_GAP=2, `tx_data`=8'h01.
  - First fall at T0+3, last rise at T0+18.
  - `rx_valid` at T0+20, `ready` at T0+22.
